// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store unit bridging the EX stage to an SRAM-style request/handshake bus
module mem_access_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    input  logic [7:0]  op_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic        flush_i,
    output logic        data_req,
    output logic        data_wr,
    output logic [3:0]  data_wen,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata,
    output logic        stall_o,
    output logic        done_o,
    output logic [31:0] rdata_o,
    output logic        adel_o,
    output logic        ades_o,
    output logic [31:0] badvaddr_o
);
    localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
    localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
    localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
    localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
    localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
    localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
    localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
    localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t      state_q;
    logic [7:0]  op_q;
    logic [31:0] addr_q, wdata_q;
    logic [3:0]  wen_q;
    logic        wr_q, kill_q;
    logic        is_load, is_store, aligned, idle_ok, accept, misal;
    logic [3:0]  wen_d;
    logic [31:0] wdata_d;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Classify the incoming op, check alignment and steer store lanes
    always_comb begin
        is_load  = op_i inside {EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP};
        is_store = op_i inside {EXE_SB_OP, EXE_SH_OP, EXE_SW_OP};
        aligned  = (op_i inside {EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP}) ? ~addr_i[0] :
                   (op_i inside {EXE_LW_OP, EXE_SW_OP}) ? (addr_i[1:0] == 2'b00) : 1'b1;
        idle_ok  = (state_q == IDLE) && valid_i && (is_load || is_store) && !flush_i && !rst;
        accept   = idle_ok && aligned;
        misal    = idle_ok && !aligned;
        wen_d    = (op_i == EXE_SB_OP) ? 4'b0001 << addr_i[1:0] :
                   (op_i == EXE_SH_OP) ? (addr_i[1] ? 4'b1100 : 4'b0011) :
                   (op_i == EXE_SW_OP) ? 4'b1111 : 4'b0000;
        wdata_d  = (op_i == EXE_SB_OP) ? {4{wdata_i[7:0]}} :
                   (op_i == EXE_SH_OP) ? {2{wdata_i[15:0]}} :
                   (op_i == EXE_SW_OP) ? wdata_i : 32'h0;
    end

    // Bus, pipeline-control, exception and load-format outputs
    always_comb begin
        data_req   = (state_q == REQ);
        data_wr    = wr_q;
        data_wen   = wen_q;
        data_addr  = addr_q;
        data_wdata = wdata_q;
        done_o     = (state_q == WAIT) && data_data_ok && !kill_q && !flush_i;
        stall_o    = accept || (state_q == REQ) || ((state_q == WAIT) && (!data_data_ok || kill_q));
        adel_o     = misal && is_load;
        ades_o     = misal && is_store;
        badvaddr_o = misal ? addr_i : 32'h0;
        byte_v     = data_rdata[{addr_q[1:0], 3'b000} +: 8];
        half_v     = addr_q[1] ? data_rdata[31:16] : data_rdata[15:0];
        rdata_o    = !done_o                ? 32'h0 :
                     (op_q == EXE_LB_OP)  ? {{24{byte_v[7]}}, byte_v} :
                     (op_q == EXE_LBU_OP) ? {24'h0, byte_v} :
                     (op_q == EXE_LH_OP)  ? {{16{half_v[15]}}, half_v} :
                     (op_q == EXE_LHU_OP) ? {16'h0, half_v} : data_rdata;
    end

    // Access FSM: capture on accept, request until addr_ok, drain the response; kill hides flushed responses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            kill_q  <= 1'b0;
            op_q    <= 8'h0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            wen_q   <= 4'h0;
            wr_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (accept) begin
                    state_q <= REQ;
                    op_q    <= op_i;
                    addr_q  <= addr_i;
                    wdata_q <= wdata_d;
                    wen_q   <= wen_d;
                    wr_q    <= is_store;
                end
                REQ: if (data_addr_ok) begin
                    state_q <= WAIT;
                    kill_q  <= flush_i;
                end else if (flush_i) begin
                    state_q <= IDLE;
                end
                WAIT: if (data_data_ok) begin
                    state_q <= IDLE;
                    kill_q  <= 1'b0;
                end else if (flush_i) begin
                    kill_q  <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: vector table, directed corner sequences and randomized transactions against a reference model
module tb_mem_access_unit;
    localparam logic [7:0] LB  = 8'b1110_0000;
    localparam logic [7:0] LH  = 8'b1110_0001;
    localparam logic [7:0] LW  = 8'b1110_0011;
    localparam logic [7:0] LBU = 8'b1110_0100;
    localparam logic [7:0] LHU = 8'b1110_0101;
    localparam logic [7:0] SB  = 8'b1110_1000;
    localparam logic [7:0] SH  = 8'b1110_1001;
    localparam logic [7:0] SW  = 8'b1110_1011;

    logic        clk = 0, rst = 1, valid_i = 0, flush_i = 0;
    logic [7:0]  op_i = 0;
    logic [31:0] addr_i = 0, wdata_i = 0, data_rdata = 0;
    logic        data_addr_ok = 0, data_data_ok = 0;
    logic        data_req, data_wr, stall_o, done_o, adel_o, ades_o;
    logic [3:0]  data_wen;
    logic [31:0] data_addr, data_wdata, rdata_o, badvaddr_o;

    int checks = 0, errors = 0;
    int dones;
    logic [31:0] last_rdata, last_wdata;
    logic [3:0]  last_wen;
    logic        last_wr;

    mem_access_unit dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .op_i(op_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .flush_i(flush_i), .data_req(data_req), .data_wr(data_wr), .data_wen(data_wen),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata), .stall_o(stall_o), .done_o(done_o),
        .rdata_o(rdata_o), .adel_o(adel_o), .ades_o(ades_o), .badvaddr_o(badvaddr_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [7:0]  op;
        logic [31:0] addr;
        logic        flush;
        logic        stall, adel, ades;
        logic [31:0] bad;
    } vec_t;
    vec_t vt[11];

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", n, act, exp);
        end
    endtask

    function automatic bit m_load(input logic [7:0] op);
        return op == LB || op == LBU || op == LH || op == LHU || op == LW;
    endfunction

    function automatic logic [3:0] m_wen(input logic [7:0] op, input logic [31:0] a);
        int off = int'(a[1:0]);
        if (op == SB) return 4'(1 << off);
        if (op == SH) return 4'(3 << off);
        if (op == SW) return 4'hF;
        return 4'h0;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [7:0] op, input logic [31:0] d);
        if (op == SB) return (d & 32'hFF) * 32'h0101_0101;
        if (op == SH) return (d & 32'hFFFF) * 32'h0001_0001;
        if (op == SW) return d;
        return 32'h0;
    endfunction

    function automatic logic [31:0] m_rdata(input logic [7:0] op, input logic [31:0] a, input logic [31:0] r);
        logic [31:0] b = (r >> (8 * int'(a[1:0]))) & 32'hFF;
        logic [31:0] h = (r >> (16 * int'(a[1]))) & 32'hFFFF;
        if (op == LB)  return (b ^ 32'h80) - 32'h80;
        if (op == LBU) return b;
        if (op == LH)  return (h ^ 32'h8000) - 32'h8000;
        if (op == LHU) return h;
        return r;
    endfunction

    // fm: 0 none, 1 flush in REQ without addr_ok, 2 flush in REQ with addr_ok, 3 flush in first WAIT cycle (dd >= 1)
    task automatic run_txn(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [31:0] rd, input int ad, input int dd, input int fm);
        bit killed = (fm == 2 || fm == 3);
        dones = 0;
        @(negedge clk);
        valid_i = 1; op_i = op; addr_i = addr; wdata_i = wd; data_rdata = rd;
        data_addr_ok = 0; data_data_ok = 0; flush_i = 0;
        #1;
        chk("accept_stall", 32'(stall_o), 1);
        chk("accept_exc", {30'h0, adel_o, ades_o}, 0);
        @(negedge clk);
        valid_i = 0; op_i = 8'h00;
        for (int i = 0; i <= ad; i++) begin
            data_addr_ok = (i == ad) && fm != 1;
            flush_i = (i == ad) && (fm == 1 || fm == 2);
            #1;
            chk("req_data_req", 32'(data_req), 1);
            chk("req_addr", data_addr, addr);
            chk("req_wen", 32'(data_wen), 32'(m_wen(op, addr)));
            chk("req_wr", 32'(data_wr), 32'(!m_load(op)));
            chk("req_wdata", data_wdata, m_wdata(op, wd));
            chk("req_stall", 32'(stall_o), 1);
            last_wen = data_wen; last_wdata = data_wdata; last_wr = data_wr;
            @(negedge clk);
        end
        data_addr_ok = 0; flush_i = 0;
        if (fm == 1) begin
            #1;
            chk("flushreq_data_req", 32'(data_req), 0);
            chk("flushreq_stall", 32'(stall_o), 0);
            return;
        end
        for (int j = 0; j <= dd; j++) begin
            flush_i = (fm == 3 && j == 0);
            data_data_ok = (j == dd);
            #1;
            chk("wait_data_req", 32'(data_req), 0);
            chk("wait_done", 32'(done_o), 32'((j == dd) && !killed));
            chk("wait_stall", 32'(stall_o), 32'((j < dd) || killed));
            if (done_o) begin
                dones++;
                last_rdata = rdata_o;
                if (m_load(op)) chk("load_rdata", rdata_o, m_rdata(op, addr, rd));
            end
            @(negedge clk);
        end
        data_data_ok = 0; flush_i = 0;
        #1;
        chk("idle_stall", 32'(stall_o), 0);
        chk("idle_done", 32'(done_o), 0);
        chk("done_count", dones, killed ? 0 : 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [7:0] mops[8] = '{LB, LBU, LH, LHU, LW, SB, SH, SW};
        vt[0]  = '{1, LW,    32'h0000_0006, 0, 0, 1, 0, 32'h0000_0006};
        vt[1]  = '{1, LH,    32'h0000_1001, 0, 0, 1, 0, 32'h0000_1001};
        vt[2]  = '{1, LHU,   32'h0000_0003, 0, 0, 1, 0, 32'h0000_0003};
        vt[3]  = '{1, SH,    32'h0000_0005, 0, 0, 0, 1, 32'h0000_0005};
        vt[4]  = '{1, SW,    32'h0000_0002, 0, 0, 0, 1, 32'h0000_0002};
        vt[5]  = '{1, SW,    32'h0000_0004, 1, 0, 0, 0, 32'h0};
        vt[6]  = '{1, 8'h21, 32'h0000_0003, 0, 0, 0, 0, 32'h0};
        vt[7]  = '{0, LW,    32'h0000_0006, 0, 0, 0, 0, 32'h0};
        vt[8]  = '{1, LB,    32'h0000_0003, 0, 1, 0, 0, 32'h0};
        vt[9]  = '{1, SW,    32'h0000_0008, 0, 1, 0, 0, 32'h0};
        vt[10] = '{1, LW,    32'h0000_0001, 1, 0, 0, 0, 32'h0};

        // reset holds everything low even with an acceptable op presented
        valid_i = 1; op_i = LW; addr_i = 32'h100; wdata_i = 32'hFFFF_FFFF;
        #3;
        chk("rst_req", 32'(data_req), 0);
        chk("rst_stall", 32'(stall_o), 0);
        chk("rst_bus", {data_wr, data_wen, data_addr | data_wdata}, 0);
        chk("rst_done_exc", {done_o, adel_o, ades_o}, 0);
        @(negedge clk);
        valid_i = 0; rst = 0;

        // single-cycle decode vectors in IDLE; valid drops before the edge so nothing is captured
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            valid_i = vt[i].valid; op_i = vt[i].op; addr_i = vt[i].addr; flush_i = vt[i].flush;
            wdata_i = $urandom;
            #1;
            chk($sformatf("vec%0d_stall", i), 32'(stall_o), 32'(vt[i].stall));
            chk($sformatf("vec%0d_adel", i), 32'(adel_o), 32'(vt[i].adel));
            chk($sformatf("vec%0d_ades", i), 32'(ades_o), 32'(vt[i].ades));
            chk($sformatf("vec%0d_bad", i), badvaddr_o, vt[i].bad);
            chk($sformatf("vec%0d_req", i), 32'(data_req), 0);
            #1;
            valid_i = 0; flush_i = 0;
        end

        // sign/zero-extended byte loads from the top lane
        run_txn(LB, 32'h0000_1003, 0, 32'h80FF_FF7F, 0, 0, 0);
        chk("lb_1003", last_rdata, 32'hFFFF_FF80);
        run_txn(LBU, 32'h0000_1003, 0, 32'h80FF_FF7F, 0, 0, 0);
        chk("lbu_1003", last_rdata, 32'h0000_0080);
        // upper-half store
        run_txn(SH, 32'h0000_2002, 32'h1234_ABCD, 0, 0, 0, 0);
        chk("sh_wen", 32'(last_wen), 32'hC);
        chk("sh_wdata", last_wdata, 32'hABCD_ABCD);
        chk("sh_wr", 32'(last_wr), 1);
        // delayed handshakes keep stall high throughout with a single done
        run_txn(LW, 32'h0000_0100, 0, 32'hDEAD_BEEF, 2, 3, 0);
        chk("lw_delay_rdata", last_rdata, 32'hDEAD_BEEF);
        // store flushed in WAIT, then a normal load
        run_txn(SW, 32'h0000_0040, 32'h5555_AAAA, 0, 0, 2, 3);
        run_txn(LW, 32'h0000_0044, 0, 32'h0BAD_F00D, 0, 0, 0);
        chk("lw_after_flush", last_rdata, 32'h0BAD_F00D);
        // flush in REQ, with and without addr_ok
        run_txn(LH, 32'h0000_0302, 0, 32'h8001_7FFE, 1, 0, 1);
        run_txn(LHU, 32'h0000_0302, 0, 32'h8001_7FFE, 0, 1, 2);

        // asynchronous reset in REQ
        @(negedge clk);
        valid_i = 1; op_i = LW; addr_i = 32'h200; wdata_i = 32'h0;
        @(negedge clk);
        valid_i = 0; op_i = 8'h00;
        #1;
        chk("rstreq_pre_req", 32'(data_req), 1);
        #1 rst = 1;
        #1;
        chk("rstreq_req_now", 32'(data_req), 0);
        chk("rstreq_stall_now", 32'(stall_o), 0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            data_addr_ok = 1; data_data_ok = 1;
            #1;
            chk("rstreq_done", 32'(done_o), 0);
            chk("rstreq_bus", {data_req, data_wr, data_wen, data_addr | data_wdata}, 0);
        end
        @(negedge clk);
        rst = 0; data_addr_ok = 0; data_data_ok = 1;
        #1;
        chk("rstreq_after_done", 32'(done_o), 0);
        chk("rstreq_after_bus", {data_req, stall_o, data_wr, data_wen, data_addr}, 0);
        data_data_ok = 0;
        run_txn(LW, 32'h0000_0208, 0, 32'h1357_9BDF, 0, 0, 0);

        // randomized transactions
        for (int t = 0; t < 40; t++) begin
            logic [7:0]  op = mops[$urandom_range(0, 7)];
            logic [31:0] a  = $urandom;
            int fm = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            int dd = $urandom_range(0, 3);
            if (op == LH || op == LHU || op == SH) a[0] = 1'b0;
            if (op == LW || op == SW) a[1:0] = 2'b00;
            if (fm == 3 && dd == 0) dd = 1;
            run_txn(op, a, $urandom, $urandom, $urandom_range(0, 2), dd, fm);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
